// File: rtl/prbs_pkg.sv
// Purpose: shared types, per-mode PRBS order/tap constants and tap-mask helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } prbs_mode_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } fsm_state_t;

  localparam int HIST_W = 31;

  // Polynomial x^ORDER + x^TAP + 1: next bit = bit(ORDER ago) ^ bit(TAP ago).
  localparam int ORDER_7  = 7;
  localparam int TAP_7    = 6;
  localparam int ORDER_15 = 15;
  localparam int TAP_15   = 14;
  localparam int ORDER_23 = 23;
  localparam int TAP_23   = 18;
  localparam int ORDER_31 = 31;
  localparam int TAP_31   = 28;

  function automatic logic [5:0] prbs_order(prbs_mode_t m);
    case (m)
      PRBS7:   return 6'(ORDER_7);
      PRBS15:  return 6'(ORDER_15);
      PRBS23:  return 6'(ORDER_23);
      default: return 6'(ORDER_31);
    endcase
  endfunction

  // History bit k-1 holds the bit received k steps ago.
  function automatic logic [HIST_W-1:0] prbs_tap_mask(prbs_mode_t m);
    logic [HIST_W-1:0] one;
    one = 31'd1;
    case (m)
      PRBS7:   return (one << (ORDER_7 - 1))  | (one << (TAP_7 - 1));
      PRBS15:  return (one << (ORDER_15 - 1)) | (one << (TAP_15 - 1));
      PRBS23:  return (one << (ORDER_23 - 1)) | (one << (TAP_23 - 1));
      default: return (one << (ORDER_31 - 1)) | (one << (TAP_31 - 1));
    endcase
  endfunction

endpackage

// File: rtl/prbs_ber_checker_if.sv
// Purpose: bundles the serial bit input, control and result readout of the BER checker.
// Latency: n/a (wiring only).
// Backpressure: none; bit_en qualifies each bit, send_data is a one-shot pulse.
// Optional PRBS_BURST_STATS_EN adds the max_burst result field.
interface prbs_ber_checker_if import prbs_pkg::*; #(
  parameter int CNT_W = 32
);
  logic             bit_in;
  logic             bit_en;
  prbs_mode_t       mode;
  logic             get_word;
  logic             locked;
  logic             send_data;
  logic [CNT_W-1:0] error_bits_out;
  logic [CNT_W-1:0] total_bits_out;
  logic             lol_seen;
`ifdef PRBS_BURST_STATS_EN
  logic [15:0]      max_burst;
  modport master (output bit_in, bit_en, mode, get_word,
                  input  locked, send_data, error_bits_out, total_bits_out, lol_seen, max_burst);
  modport slave  (input  bit_in, bit_en, mode, get_word,
                  output locked, send_data, error_bits_out, total_bits_out, lol_seen, max_burst);
`else
  modport master (output bit_in, bit_en, mode, get_word,
                  input  locked, send_data, error_bits_out, total_bits_out, lol_seen);
  modport slave  (input  bit_in, bit_en, mode, get_word,
                  output locked, send_data, error_bits_out, total_bits_out, lol_seen);
`endif
endinterface

// File: rtl/prbs_lfsr.sv
// Purpose: 31-bit PRBS history/predictor; shifts in received data or its own prediction.
// Latency: prediction is combinational from history; history updates 1 clk after adv.
// Backpressure: none; history only moves on adv.
module prbs_lfsr import prbs_pkg::*; #(
  parameter int W = HIST_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       load_in,
  input  logic       din,
  input  prbs_mode_t mode,
  output logic       pred
);
  logic [W-1:0] hist;
  logic [W-1:0] mask;

  assign mask = W'(prbs_tap_mask(mode));
  assign pred = ^(hist & mask);

  // Shift register: received bit while searching, predicted bit when free-running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist <= '0;
    else if (adv) hist <= {hist[W-2:0], (load_in ? din : pred)};
  end
endmodule

// File: rtl/prbs_ber_checker.sv
// Purpose: self-syncing PRBS7/15/23/31 BER checker with lock FSM and windowed measurement.
// Latency: counters update 1 clk after a bit is consumed; results and send_data 1 clk after the final bit.
// Backpressure: none; one bit per bit_en, results are a one-clk pulse. Optional PRBS_BURST_STATS_EN adds max_burst.
module prbs_ber_checker import prbs_pkg::*; #(
  parameter int CNT_W      = 32,
  parameter int MEAS_BITS  = 1000000,
  parameter int LOCK_CNT   = 64,
  parameter int LOL_WIN    = 256,
  parameter int LOL_THRESH = 32
) (
  input logic clk,
  input logic rst,
  prbs_ber_checker_if.slave io
);
  localparam logic [15:0]      LOCK_M1 = 16'(LOCK_CNT - 1);
  localparam logic [15:0]      THR_M1  = 16'(LOL_THRESH - 1);
  localparam logic [15:0]      WIN_M1  = 16'(LOL_WIN - 1);
  localparam logic [CNT_W-1:0] MEAS    = CNT_W'(MEAS_BITS);
  localparam logic [CNT_W-1:0] CMAX    = '1;

  fsm_state_t       state, state_nxt;
  prbs_mode_t       mode_q;
  logic [5:0]       fill_cnt;
  logic [15:0]      match_cnt, lol_cnt, lol_pos;
  logic             pred, mismatch, pred_valid, mode_chg, go_lock, go_lol;
  logic             locked_o, count_en;
  logic             gw_q, gw_rise, start, run, done;
  logic [CNT_W-1:0] err_cnt, tot_cnt, err_inc, tot_inc, err_out, tot_out;
  logic             send_r, lol_seen_r;

  prbs_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv     (io.bit_en),
    .load_in (state == SEARCH),
    .din     (io.bit_in),
    .mode    (mode_q),
    .pred    (pred)
  );

  assign mismatch   = io.bit_in ^ pred;
  assign pred_valid = (fill_cnt >= prbs_order(mode_q));
  assign mode_chg   = (io.mode != mode_q);
  assign go_lock    = (state == SEARCH) && io.bit_en && !mode_chg && pred_valid &&
                      !mismatch && (match_cnt == LOCK_M1);
  assign go_lol     = (state == LOCKED) && io.bit_en && mismatch && (lol_cnt == THR_M1);

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEARCH;
    else      state <= state_nxt;
  end

  // Lock FSM transitions: lock on LOCK_CNT good predictions, drop on errors or mode change.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (go_lock) state_nxt = LOCKED;
      LOCKED:  if (mode_chg || go_lol) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // Lock FSM outputs: lock indication and measurement bit qualifier.
  always_comb begin
    locked_o = 1'b0;
    count_en = 1'b0;
    if (state == LOCKED) begin
      locked_o = 1'b1;
      count_en = io.bit_en;
    end
  end

  // Search bookkeeping: mode capture, fresh-bit fill count, consecutive match count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= PRBS7;
      fill_cnt  <= '0;
      match_cnt <= '0;
    end else if (state == SEARCH) begin
      if (mode_chg) begin
        mode_q    <= io.mode;
        fill_cnt  <= '0;
        match_cnt <= '0;
      end else if (io.bit_en) begin
        if (fill_cnt < 6'(HIST_W)) fill_cnt <= fill_cnt + 6'd1;
        if (pred_valid) match_cnt <= mismatch ? 16'd0 : match_cnt + 16'd1;
      end
    end else begin
      fill_cnt  <= '0;
      match_cnt <= '0;
    end
  end

  // Loss-of-lock: errors per LOL_WIN-bit block, block aligned to lock entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lol_cnt <= '0;
      lol_pos <= '0;
    end else if (state != LOCKED) begin
      lol_cnt <= '0;
      lol_pos <= '0;
    end else if (io.bit_en) begin
      if (lol_pos == WIN_M1) begin
        lol_pos <= '0;
        lol_cnt <= '0;
      end else begin
        lol_pos <= lol_pos + 16'd1;
        if (mismatch) lol_cnt <= lol_cnt + 16'd1;
      end
    end
  end

  assign gw_rise = io.get_word & ~gw_q;
  assign start   = !run && gw_rise;
  assign tot_inc = (tot_cnt == CMAX) ? tot_cnt : tot_cnt + 1'b1;
  assign err_inc = (mismatch && err_cnt != CMAX) ? err_cnt + 1'b1 : err_cnt;
  assign done    = run && count_en && (tot_inc == MEAS);

  // Measurement run: count locked bits, latch results and pulse send_data on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gw_q    <= 1'b0;
      run     <= 1'b0;
      tot_cnt <= '0;
      err_cnt <= '0;
      tot_out <= '0;
      err_out <= '0;
      send_r  <= 1'b0;
    end else begin
      gw_q   <= io.get_word;
      send_r <= 1'b0;
      if (run) begin
        if (count_en) begin
          tot_cnt <= tot_inc;
          err_cnt <= err_inc;
        end
        if (done) begin
          tot_out <= tot_inc;
          err_out <= err_inc;
          send_r  <= 1'b1;
          run     <= 1'b0;
        end
      end else if (gw_rise) begin
        run     <= 1'b1;
        tot_cnt <= '0;
        err_cnt <= '0;
      end
    end
  end

  // Sticky loss-of-lock flag, cleared when a new run starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lol_seen_r <= 1'b0;
    else if (go_lol) lol_seen_r <= 1'b1;
    else if (start)  lol_seen_r <= 1'b0;
  end

  assign io.locked         = locked_o;
  assign io.send_data      = send_r;
  assign io.error_bits_out = err_out;
  assign io.total_bits_out = tot_out;
  assign io.lol_seen       = lol_seen_r;

`ifdef PRBS_BURST_STATS_EN
  logic [15:0] cur_burst, max_w, max_q, burst_inc;
  assign burst_inc = (cur_burst == 16'hFFFF) ? cur_burst : cur_burst + 16'd1;

  // Longest run of consecutive errored locked bits, latched with the results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_burst <= '0;
      max_w     <= '0;
      max_q     <= '0;
    end else if (start) begin
      cur_burst <= '0;
      max_w     <= '0;
    end else if (run && count_en) begin
      if (mismatch) begin
        cur_burst <= burst_inc;
        if (burst_inc > max_w) max_w <= burst_inc;
      end else begin
        cur_burst <= '0;
      end
      if (done) max_q <= (mismatch && burst_inc > max_w) ? burst_inc : max_w;
    end
  end

  assign io.max_burst = max_q;
`endif
endmodule

// File: tb/tb_prbs_ber_checker.sv
// Purpose: scoreboard bench for prbs_ber_checker over directed PRBS streams on three configurations.
// Latency: expects send_data on the clock after the final counted bit.
// Backpressure: none; stimulus drives one bit per clk.
module tb_prbs_ber_checker;
  import prbs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, bit_in, bit_en, get_word, sel;
  prbs_mode_t mode;
  logic [30:0] g;

  prbs_ber_checker_if #(.CNT_W(32)) ifa ();
  prbs_ber_checker_if #(.CNT_W(8))  ifb ();
  prbs_ber_checker_if #(.CNT_W(8))  ifc ();

  assign ifa.bit_in = bit_in;  assign ifa.mode = mode;
  assign ifa.bit_en = bit_en & ~sel;  assign ifa.get_word = get_word & ~sel;
  assign ifb.bit_in = bit_in;  assign ifb.mode = mode;
  assign ifb.bit_en = bit_en & sel;   assign ifb.get_word = get_word & sel;
  assign ifc.bit_in = bit_in;  assign ifc.mode = mode;
  assign ifc.bit_en = bit_en & sel;   assign ifc.get_word = get_word & sel;

  prbs_ber_checker #(.CNT_W(32), .MEAS_BITS(1000)) dut_a (.clk(clk), .rst(rst), .io(ifa));
  prbs_ber_checker #(.CNT_W(8), .MEAS_BITS(200), .LOL_THRESH(257)) dut_b (.clk(clk), .rst(rst), .io(ifb));
  prbs_ber_checker #(.CNT_W(8), .MEAS_BITS(255), .LOL_THRESH(257)) dut_c (.clk(clk), .rst(rst), .io(ifc));

  typedef struct {
    logic [31:0] err;
    logic [31:0] tot;
    logic        lol;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int which, input int e, input int t, input bit l);
    exp_t x;
    x.err = e; x.tot = t; x.lol = l;
    if (which == 0) qa.push_back(x);
    else if (which == 1) qb.push_back(x);
    else qc.push_back(x);
  endtask

  // Scoreboard monitors: compare each send_data pulse against the queued expectation.
  always @(negedge clk) if (rst === 1'b1 && ifa.send_data === 1'b1) begin
    if (qa.size() == 0) begin n_chk++; $display("FAIL a_unexpected_send: got pulse expected none"); end
    else begin
      ea = qa.pop_front();
      check("a_err", ifa.error_bits_out, ea.err);
      check("a_tot", ifa.total_bits_out, ea.tot);
      check("a_lol", 32'(ifa.lol_seen), 32'(ea.lol));
    end
  end

  always @(negedge clk) if (rst === 1'b1 && ifb.send_data === 1'b1) begin
    if (qb.size() == 0) begin n_chk++; $display("FAIL b_unexpected_send: got pulse expected none"); end
    else begin
      eb = qb.pop_front();
      check("b_err", 32'(ifb.error_bits_out), eb.err);
      check("b_tot", 32'(ifb.total_bits_out), eb.tot);
      check("b_lol", 32'(ifb.lol_seen), 32'(eb.lol));
    end
  end

  always @(negedge clk) if (rst === 1'b1 && ifc.send_data === 1'b1) begin
    if (qc.size() == 0) begin n_chk++; $display("FAIL c_unexpected_send: got pulse expected none"); end
    else begin
      ec = qc.pop_front();
      check("c_err", 32'(ifc.error_bits_out), ec.err);
      check("c_tot", 32'(ifc.total_bits_out), ec.tot);
      check("c_lol", 32'(ifc.lol_seen), 32'(ec.lol));
    end
  end

  // Reference PRBS source; per = period of single flipped bits, inv flips every bit.
  task automatic drive(input int n, input int per, input bit inv);
    logic nb;
    for (int i = 0; i < n; i++) begin
      case (mode)
        PRBS7:   nb = g[6] ^ g[5];
        PRBS15:  nb = g[14] ^ g[13];
        PRBS23:  nb = g[22] ^ g[17];
        default: nb = g[30] ^ g[27];
      endcase
      g = {g[29:0], nb};
      bit_in = nb ^ (inv || (per != 0 && (i % per) == per - 1));
      bit_en = 1'b1;
      @(posedge clk); #1;
    end
    bit_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input prbs_mode_t m);
    mode = m;
    idle(3);
    g = 31'd1;
  endtask

  task automatic pulse_gw();
    get_word = 1'b1;
    idle(1);
    get_word = 1'b0;
    idle(1);
  endtask

  task automatic end_of_run(input string name, input int which);
    @(negedge clk); #1;
    if (which == 0) check(name, qa.size(), 0);
    else if (which == 1) check(name, qb.size(), 0);
    else check(name, qc.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; bit_in = 1'b0; bit_en = 1'b0; get_word = 1'b0; sel = 1'b0;
    mode = PRBS7; g = 31'd1;
    idle(2);
    check("rst_locked", 32'(ifa.locked), 0);
    check("rst_send", 32'(ifa.send_data), 0);
    check("rst_err", ifa.error_bits_out, 0);
    check("rst_tot", ifa.total_bits_out, 0);
    check("rst_lol", 32'(ifa.lol_seen), 0);
    rst = 1'b1;
    idle(2);

    // Clean PRBS7: lock exactly on bit 7+64, 1000 clean bits.
    pulse_gw();
    push(0, 0, 1000, 0);
    drive(70, 0, 0);  check("p7_unlocked_70", 32'(ifa.locked), 0);
    drive(1, 0, 0);   check("p7_locked_71", 32'(ifa.locked), 1);
    drive(999, 0, 0); check("p7_not_early", qa.size(), 1);
    drive(1, 0, 0);   end_of_run("p7_done", 0);

    // PRBS31 with one flipped bit every 100th locked bit.
    set_mode(PRBS31);
    check("p31_mode_unlock", 32'(ifa.locked), 0);
    drive(94, 0, 0);  check("p31_unlocked_94", 32'(ifa.locked), 0);
    drive(1, 0, 0);   check("p31_locked_95", 32'(ifa.locked), 1);
    pulse_gw();
    push(0, 10, 1000, 0);
    drive(1000, 100, 0);
    end_of_run("p31_done", 0);

    // PRBS15: 40-bit error burst forces loss of lock on the 32nd error, then relock.
    set_mode(PRBS15);
    drive(79, 0, 0);  check("p15_locked", 32'(ifa.locked), 1);
    pulse_gw();
    push(0, 32, 1000, 1);
    drive(300, 0, 0);
    drive(31, 0, 1);  check("p15_hold_31err", 32'(ifa.locked), 1);
    drive(1, 0, 1);   check("p15_lol_32err", 32'(ifa.locked), 0);
    drive(8, 0, 1);
    drive(900, 0, 0);
    end_of_run("p15_done", 0);

    // PRBS7 locked, then mode switch to PRBS23 mid-run; only locked bits are counted.
    set_mode(PRBS7);
    drive(71, 0, 0);  check("mc_locked_p7", 32'(ifa.locked), 1);
    pulse_gw();
    push(0, 0, 1000, 0);
    drive(100, 0, 0);
    mode = PRBS23;
    idle(1);          check("mc_unlock_next_clk", 32'(ifa.locked), 0);
    idle(2);
    g = 31'd1;
    drive(86, 0, 0);  check("mc_unlocked_86", 32'(ifa.locked), 0);
    drive(1, 0, 0);   check("mc_locked_87", 32'(ifa.locked), 1);
    drive(899, 0, 0); check("mc_not_early", qa.size(), 1);
    drive(1, 0, 0);   end_of_run("mc_done", 0);

    // 8-bit counters, every locked bit errored, loss of lock disabled.
    sel = 1'b1;
    set_mode(PRBS7);
    drive(71, 0, 0);
    check("b_locked", 32'(ifb.locked), 1);
    check("c_locked", 32'(ifc.locked), 1);
    pulse_gw();
    push(1, 200, 200, 0);
    push(2, 255, 255, 0);
    drive(254, 0, 1);
    check("b_done_at_200", qb.size(), 0);
    check("c_not_early", qc.size(), 1);
    drive(1, 0, 1);
    end_of_run("c_done", 2);
    check("b_still_locked", 32'(ifb.locked), 1);

    // Asynchronous reset in the middle of a run, then a clean run.
    sel = 1'b0;
    set_mode(PRBS7);
    drive(71, 0, 0);
    pulse_gw();
    drive(300, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_locked", 32'(ifa.locked), 0);
    check("arst_send", 32'(ifa.send_data), 0);
    check("arst_err", ifa.error_bits_out, 0);
    check("arst_tot", ifa.total_bits_out, 0);
    check("arst_lol", 32'(ifa.lol_seen), 0);
    idle(1);
    rst = 1'b1;
    idle(2);
    g = 31'd1;
    drive(71, 0, 0);  check("post_rst_locked", 32'(ifa.locked), 1);
    pulse_gw();
    push(0, 0, 1000, 0);
    drive(1000, 0, 0);
    end_of_run("post_rst_done", 0);

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
